// File: rtl/alu_operand_stage.sv
// ID/EX pipeline register with operand forwarding for the ALU inputs.
// Holds one decoded instruction and resolves RAW hazards against the EX/MEM
// and MEM/WB stages, either combinationally on the way out or by capturing a
// writeback into the held operand registers.
module alu_operand_stage #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  // Decode stage
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  input  logic [REG_ADDR_W-1:0] id_rd_addr,
  input  logic [XLEN-1:0]       id_rs1_data,
  input  logic [XLEN-1:0]       id_rs2_data,
  input  logic [XLEN-1:0]       id_imm,
  input  logic                  id_alu_src,
  input  logic [3:0]            id_alu_control,
  input  logic                  id_reg_write,
  // Hazard unit
  input  logic                  stall,
  input  logic                  flush,
  // EX/MEM forwarding source
  input  logic                  mem_reg_write,
  input  logic [REG_ADDR_W-1:0] mem_rd_addr,
  input  logic [XLEN-1:0]       mem_result,
  // MEM/WB forwarding source
  input  logic                  wb_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_rd_addr,
  input  logic [XLEN-1:0]       wb_result,
  // ALU side
  output logic [XLEN-1:0]       A,
  output logic [XLEN-1:0]       B,
  output logic [3:0]            ALU_control,
  output logic                  ex_valid,
  output logic [REG_ADDR_W-1:0] ex_rd_addr,
  output logic                  ex_reg_write,
  output logic [XLEN-1:0]       ex_store_data,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b
);

  localparam logic [1:0] FwdReg = 2'b00;
  localparam logic [1:0] FwdWb  = 2'b01;
  localparam logic [1:0] FwdMem = 2'b10;

  localparam logic [REG_ADDR_W-1:0] RegZero = '0;

  // Stage registers
  logic                  r_valid;
  logic                  r_reg_write;
  logic [REG_ADDR_W-1:0] r_rd_addr;
  logic [3:0]            r_alu_control;
  logic [REG_ADDR_W-1:0] r_rs1_addr;
  logic [REG_ADDR_W-1:0] r_rs2_addr;
  logic [XLEN-1:0]       r_rs1_data;
  logic [XLEN-1:0]       r_rs2_data;
  logic [XLEN-1:0]       r_imm;
  logic                  r_alu_src;

  // Next-state values
  logic                  w_valid_d;
  logic                  w_reg_write_d;
  logic [REG_ADDR_W-1:0] w_rd_addr_d;
  logic [3:0]            w_alu_control_d;
  logic [REG_ADDR_W-1:0] w_rs1_addr_d;
  logic [REG_ADDR_W-1:0] w_rs2_addr_d;
  logic [XLEN-1:0]       w_rs1_data_d;
  logic [XLEN-1:0]       w_rs2_data_d;
  logic [XLEN-1:0]       w_imm_d;
  logic                  w_alu_src_d;

  // Writeback / EX-MEM match terms; address 0 never matches
  logic w_wb_wr;
  logic w_mem_wr;
  logic w_wb_hit_id_rs1;
  logic w_wb_hit_id_rs2;
  logic w_wb_hit_rs1;
  logic w_wb_hit_rs2;
  logic w_mem_hit_rs1;
  logic w_mem_hit_rs2;

  // Forwarded operand values
  logic [XLEN-1:0] w_rs1_fwd;
  logic [XLEN-1:0] w_rs2_fwd;

  // Qualify forwarding sources once so the compares below stay readable
  always_comb begin
    w_wb_wr  = wb_reg_write  && (wb_rd_addr  != RegZero);
    w_mem_wr = mem_reg_write && (mem_rd_addr != RegZero);

    w_wb_hit_id_rs1 = w_wb_wr && (wb_rd_addr == id_rs1_addr);
    w_wb_hit_id_rs2 = w_wb_wr && (wb_rd_addr == id_rs2_addr);

    w_wb_hit_rs1  = w_wb_wr  && (wb_rd_addr  == r_rs1_addr);
    w_wb_hit_rs2  = w_wb_wr  && (wb_rd_addr  == r_rs2_addr);
    w_mem_hit_rs1 = w_mem_wr && (mem_rd_addr == r_rs1_addr);
    w_mem_hit_rs2 = w_mem_wr && (mem_rd_addr == r_rs2_addr);
  end

  // Next-state selection: flush beats stall beats load
  always_comb begin
    w_valid_d       = r_valid;
    w_reg_write_d   = r_reg_write;
    w_rd_addr_d     = r_rd_addr;
    w_alu_control_d = r_alu_control;
    w_rs1_addr_d    = r_rs1_addr;
    w_rs2_addr_d    = r_rs2_addr;
    w_rs1_data_d    = r_rs1_data;
    w_rs2_data_d    = r_rs2_data;
    w_imm_d         = r_imm;
    w_alu_src_d     = r_alu_src;

    if (flush) begin
      // Bubble: zero addresses guarantee no forwarding, so A = B = 0
      w_valid_d       = 1'b0;
      w_reg_write_d   = 1'b0;
      w_rd_addr_d     = '0;
      w_alu_control_d = 4'b0000;
      w_rs1_addr_d    = '0;
      w_rs2_addr_d    = '0;
      w_rs1_data_d    = '0;
      w_rs2_data_d    = '0;
      w_imm_d         = '0;
      w_alu_src_d     = 1'b0;
    end else if (stall) begin
      // A writeback landing while we wait must not be lost once WB moves on
      if (w_wb_hit_rs1) begin
        w_rs1_data_d = wb_result;
      end
      if (w_wb_hit_rs2) begin
        w_rs2_data_d = wb_result;
      end
    end else begin
      w_valid_d       = id_valid;
      w_reg_write_d   = id_valid && id_reg_write;
      w_rd_addr_d     = id_rd_addr;
      w_alu_control_d = id_alu_control;
      w_rs1_addr_d    = id_rs1_addr;
      w_rs2_addr_d    = id_rs2_addr;
      w_imm_d         = id_imm;
      w_alu_src_d     = id_alu_src;
      // Register file read happens in the same cycle as the WB write
      w_rs1_data_d    = w_wb_hit_id_rs1 ? wb_result : id_rs1_data;
      w_rs2_data_d    = w_wb_hit_id_rs2 ? wb_result : id_rs2_data;
    end
  end

  // Stage register update with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid       <= 1'b0;
      r_reg_write   <= 1'b0;
      r_rd_addr     <= '0;
      r_alu_control <= 4'b0000;
      r_rs1_addr    <= '0;
      r_rs2_addr    <= '0;
      r_rs1_data    <= '0;
      r_rs2_data    <= '0;
      r_imm         <= '0;
      r_alu_src     <= 1'b0;
    end else begin
      r_valid       <= w_valid_d;
      r_reg_write   <= w_reg_write_d;
      r_rd_addr     <= w_rd_addr_d;
      r_alu_control <= w_alu_control_d;
      r_rs1_addr    <= w_rs1_addr_d;
      r_rs2_addr    <= w_rs2_addr_d;
      r_rs1_data    <= w_rs1_data_d;
      r_rs2_data    <= w_rs2_data_d;
      r_imm         <= w_imm_d;
      r_alu_src     <= w_alu_src_d;
    end
  end

  // Forwarding mux: youngest producer (EX/MEM) wins over MEM/WB
  always_comb begin
    if (w_mem_hit_rs1) begin
      fwd_a     = FwdMem;
      w_rs1_fwd = mem_result;
    end else if (w_wb_hit_rs1) begin
      fwd_a     = FwdWb;
      w_rs1_fwd = wb_result;
    end else begin
      fwd_a     = FwdReg;
      w_rs1_fwd = r_rs1_data;
    end

    if (w_mem_hit_rs2) begin
      fwd_b     = FwdMem;
      w_rs2_fwd = mem_result;
    end else if (w_wb_hit_rs2) begin
      fwd_b     = FwdWb;
      w_rs2_fwd = wb_result;
    end else begin
      fwd_b     = FwdReg;
      w_rs2_fwd = r_rs2_data;
    end
  end

  // ALU-facing outputs; store data always tracks rs2 even for immediate ops
  always_comb begin
    A             = w_rs1_fwd;
    B             = r_alu_src ? r_imm : w_rs2_fwd;
    ex_store_data = w_rs2_fwd;
    ALU_control   = r_alu_control;
    ex_valid      = r_valid;
    ex_rd_addr    = r_rd_addr;
    ex_reg_write  = r_reg_write;
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: load, forwarding priority, x0 guard,
// stall capture, same-cycle WB bypass, flush and reset behaviour.
module tb_alu_operand_stage;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;

  logic                  clk;
  logic                  rst;
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1_addr;
  logic [REG_ADDR_W-1:0] id_rs2_addr;
  logic [REG_ADDR_W-1:0] id_rd_addr;
  logic [XLEN-1:0]       id_rs1_data;
  logic [XLEN-1:0]       id_rs2_data;
  logic [XLEN-1:0]       id_imm;
  logic                  id_alu_src;
  logic [3:0]            id_alu_control;
  logic                  id_reg_write;
  logic                  stall;
  logic                  flush;
  logic                  mem_reg_write;
  logic [REG_ADDR_W-1:0] mem_rd_addr;
  logic [XLEN-1:0]       mem_result;
  logic                  wb_reg_write;
  logic [REG_ADDR_W-1:0] wb_rd_addr;
  logic [XLEN-1:0]       wb_result;
  logic [XLEN-1:0]       A;
  logic [XLEN-1:0]       B;
  logic [3:0]            ALU_control;
  logic                  ex_valid;
  logic [REG_ADDR_W-1:0] ex_rd_addr;
  logic                  ex_reg_write;
  logic [XLEN-1:0]       ex_store_data;
  logic [1:0]            fwd_a;
  logic [1:0]            fwd_b;

  int vectors;
  int miscompares;

  alu_operand_stage #(
    .XLEN       (XLEN),
    .REG_ADDR_W (REG_ADDR_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .id_valid       (id_valid),
    .id_rs1_addr    (id_rs1_addr),
    .id_rs2_addr    (id_rs2_addr),
    .id_rd_addr     (id_rd_addr),
    .id_rs1_data    (id_rs1_data),
    .id_rs2_data    (id_rs2_data),
    .id_imm         (id_imm),
    .id_alu_src     (id_alu_src),
    .id_alu_control (id_alu_control),
    .id_reg_write   (id_reg_write),
    .stall          (stall),
    .flush          (flush),
    .mem_reg_write  (mem_reg_write),
    .mem_rd_addr    (mem_rd_addr),
    .mem_result     (mem_result),
    .wb_reg_write   (wb_reg_write),
    .wb_rd_addr     (wb_rd_addr),
    .wb_result      (wb_result),
    .A              (A),
    .B              (B),
    .ALU_control    (ALU_control),
    .ex_valid       (ex_valid),
    .ex_rd_addr     (ex_rd_addr),
    .ex_reg_write   (ex_reg_write),
    .ex_store_data  (ex_store_data),
    .fwd_a          (fwd_a),
    .fwd_b          (fwd_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit past it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic [31:0] d1,
                        input logic [4:0] rs2, input logic [31:0] d2, input logic [4:0] rd,
                        input logic src, input logic [31:0] imm, input logic [3:0] ctrl);
    id_valid       = v;
    id_rs1_addr    = rs1;
    id_rs1_data    = d1;
    id_rs2_addr    = rs2;
    id_rs2_data    = d2;
    id_rd_addr     = rd;
    id_alu_src     = src;
    id_imm         = imm;
    id_alu_control = ctrl;
    id_reg_write   = 1'b1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;

    // Reset with random inputs everywhere
    rst           = 1'b1;
    stall         = 1'b0;
    flush         = 1'b0;
    set_id(1'b1, 5'($urandom), $urandom, 5'($urandom), $urandom, 5'($urandom),
           1'($urandom), $urandom, 4'($urandom));
    mem_reg_write = 1'($urandom);
    mem_rd_addr   = 5'($urandom);
    mem_result    = $urandom;
    wb_reg_write  = 1'($urandom);
    wb_rd_addr    = 5'($urandom);
    wb_result     = $urandom;
    step();
    step();
    check("rst_A", A, 32'h0);
    check("rst_B", B, 32'h0);
    check("rst_ctrl", 32'(ALU_control), 32'h0);
    check("rst_valid", 32'(ex_valid), 32'h0);
    check("rst_regwr", 32'(ex_reg_write), 32'h0);
    check("rst_fwd_a", 32'(fwd_a), 32'h0);
    check("rst_fwd_b", 32'(fwd_b), 32'h0);
    check("rst_store", ex_store_data, 32'h0);

    // Plain load, register operand
    rst           = 1'b0;
    mem_reg_write = 1'b0;
    wb_reg_write  = 1'b0;
    set_id(1'b1, 5'd3, 32'd10, 5'd4, 32'd20, 5'd9, 1'b0, 32'h0, 4'b0001);
    step();
    check("ld_A", A, 32'd10);
    check("ld_B", B, 32'd20);
    check("ld_ctrl", 32'(ALU_control), 32'h1);
    check("ld_fwd_a", 32'(fwd_a), 32'h0);
    check("ld_fwd_b", 32'(fwd_b), 32'h0);
    check("ld_valid", 32'(ex_valid), 32'h1);
    check("ld_regwr", 32'(ex_reg_write), 32'h1);
    check("ld_rd", 32'(ex_rd_addr), 32'd9);

    // Plain load, immediate operand
    set_id(1'b1, 5'd3, 32'd10, 5'd4, 32'd20, 5'd9, 1'b1, 32'hFFFF_FFFC, 4'b0001);
    step();
    check("imm_B", B, 32'hFFFF_FFFC);
    check("imm_store", ex_store_data, 32'd20);
    check("imm_A", A, 32'd10);

    // Forwarding priority on held rs1=5
    set_id(1'b1, 5'd5, 32'h11, 5'd6, 32'h22, 5'd10, 1'b0, 32'h0, 4'b0010);
    step();
    mem_reg_write = 1'b1;
    mem_rd_addr   = 5'd5;
    mem_result    = 32'h55;
    wb_reg_write  = 1'b1;
    wb_rd_addr    = 5'd5;
    wb_result     = 32'h66;
    #1;
    check("fwd_both_A", A, 32'h55);
    check("fwd_both_sel", 32'(fwd_a), 32'h2);
    check("fwd_both_B", B, 32'h22);
    mem_reg_write = 1'b0;
    #1;
    check("fwd_wb_A", A, 32'h66);
    check("fwd_wb_sel", 32'(fwd_a), 32'h1);
    mem_reg_write = 1'b1;
    mem_rd_addr   = 5'd0;
    #1;
    check("fwd_mem_x0_A", A, 32'h66);
    check("fwd_mem_x0_sel", 32'(fwd_a), 32'h1);
    wb_reg_write  = 1'b0;
    #1;
    check("fwd_none_A", A, 32'h11);
    check("fwd_none_sel", 32'(fwd_a), 32'h0);

    // x0 guard: held rs1 = rs2 = 0
    mem_reg_write = 1'b0;
    set_id(1'b1, 5'd0, 32'h0, 5'd0, 32'h0, 5'd11, 1'b0, 32'h0, 4'b0011);
    step();
    mem_reg_write = 1'b1;
    mem_rd_addr   = 5'd0;
    mem_result    = 32'h0000_DEAD;
    #1;
    check("x0_A", A, 32'h0);
    check("x0_fwd_a", 32'(fwd_a), 32'h0);
    check("x0_B", B, 32'h0);
    check("x0_fwd_b", 32'(fwd_b), 32'h0);

    // Stall capture of a writeback to held rs2=7
    mem_reg_write = 1'b0;
    set_id(1'b1, 5'd1, 32'h5, 5'd7, 32'h1, 5'd12, 1'b0, 32'h0, 4'b0011);
    step();
    stall        = 1'b1;
    set_id(1'b1, 5'd20, 32'hAAAA, 5'd21, 32'hBBBB, 5'd22, 1'b1, 32'h1234, 4'b1001);
    wb_reg_write = 1'b1;
    wb_rd_addr   = 5'd7;
    wb_result    = 32'h99;
    #1;
    check("stl_B_fwd", B, 32'h99);
    check("stl_fwd_b_wb", 32'(fwd_b), 32'h1);
    step();
    wb_reg_write = 1'b0;
    #1;
    check("stl_B_cap", B, 32'h99);
    check("stl_fwd_b_reg", 32'(fwd_b), 32'h0);
    check("stl_ctrl_hold", 32'(ALU_control), 32'h3);
    check("stl_A_hold", A, 32'h5);
    step();
    check("stl_B_hold2", B, 32'h99);
    stall = 1'b0;
    #1;
    check("stl_B_release", B, 32'h99);

    // Same-cycle WB bypass into the load
    set_id(1'b1, 5'd8, 32'h123, 5'd9, 32'h456, 5'd13, 1'b0, 32'h0, 4'b0100);
    wb_reg_write = 1'b1;
    wb_rd_addr   = 5'd8;
    wb_result    = 32'hABCD;
    step();
    wb_reg_write = 1'b0;
    #1;
    check("byp_A", A, 32'hABCD);
    check("byp_fwd_a", 32'(fwd_a), 32'h0);
    check("byp_B", B, 32'h456);

    // EX/MEM forward to store data while B takes the immediate
    set_id(1'b1, 5'd8, 32'h123, 5'd9, 32'h456, 5'd13, 1'b1, 32'h10, 4'b0000);
    step();
    mem_reg_write = 1'b1;
    mem_rd_addr   = 5'd9;
    mem_result    = 32'hBEEF;
    #1;
    check("st_B_imm", B, 32'h10);
    check("st_data", ex_store_data, 32'hBEEF);
    check("st_fwd_b", 32'(fwd_b), 32'h2);

    // Flush together with stall yields a bubble
    mem_reg_write = 1'b0;
    flush         = 1'b1;
    stall         = 1'b1;
    set_id(1'b1, 5'd3, 32'd10, 5'd4, 32'd20, 5'd9, 1'b0, 32'h0, 4'b0111);
    step();
    flush = 1'b0;
    stall = 1'b0;
    #1;
    check("fl_valid", 32'(ex_valid), 32'h0);
    check("fl_regwr", 32'(ex_reg_write), 32'h0);
    check("fl_A", A, 32'h0);
    check("fl_B", B, 32'h0);
    check("fl_ctrl", 32'(ALU_control), 32'h0);
    check("fl_rd", 32'(ex_rd_addr), 32'h0);

    // Invalid decode slot loads a non-writing bubble
    set_id(1'b0, 5'd3, 32'd10, 5'd4, 32'd20, 5'd9, 1'b0, 32'h0, 4'b0001);
    step();
    check("inv_valid", 32'(ex_valid), 32'h0);
    check("inv_regwr", 32'(ex_reg_write), 32'h0);

    // Asynchronous reset in the middle of a stall
    set_id(1'b1, 5'd3, 32'd10, 5'd4, 32'd20, 5'd9, 1'b0, 32'h0, 4'b0001);
    step();
    check("pre_rst_A", A, 32'd10);
    stall = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", 32'(ex_valid), 32'h0);
    check("arst_A", A, 32'h0);
    check("arst_ctrl", 32'(ALU_control), 32'h0);
    rst   = 1'b0;
    stall = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
ID/EX pipeline register and operand-forwarding unit. It sits directly upstream of the ALU and drives its A, B and ALU_control inputs. It latches decoded instructions from the decode stage and resolves RAW hazards by forwarding from EX/MEM and MEM/WB. It supports stall (hold) and flush (bubble) control from the hazard unit.

Parameters:
XLEN, 32, datapath width of operands, immediate and results
REG_ADDR_W, 5, register address width (32 architectural registers, x0 hardwired zero)

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-high reset
id_valid  input  1  decode stage presents a real instruction
id_rs1_addr  input  REG_ADDR_W  source register 1 address
id_rs2_addr  input  REG_ADDR_W  source register 2 address
id_rd_addr  input  REG_ADDR_W  destination register address
id_rs1_data  input  XLEN  register-file read data for rs1
id_rs2_data  input  XLEN  register-file read data for rs2
id_imm  input  XLEN  sign-extended immediate
id_alu_src  input  1  1: B comes from the immediate; 0: B comes from rs2
id_alu_control  input  4  ALU opcode (0000 ADD … 1001 SLTU)
id_reg_write  input  1  instruction writes rd
stall  input  1  hold the current stage contents
flush  input  1  replace the stage contents with a bubble
mem_reg_write  input  1  EX/MEM instruction writes a register
mem_rd_addr  input  REG_ADDR_W  EX/MEM destination register
mem_result  input  XLEN  EX/MEM ALU result
wb_reg_write  input  1  MEM/WB writes the register file this cycle
wb_rd_addr  input  REG_ADDR_W  MEM/WB destination register
wb_result  input  XLEN  MEM/WB writeback value
A  output  XLEN  ALU operand A
B  output  XLEN  ALU operand B
ALU_control  output  4  ALU opcode
ex_valid  output  1  stage holds a real instruction
ex_rd_addr  output  REG_ADDR_W  destination register passed downstream
ex_reg_write  output  1  register write enable passed downstream (0 for a bubble)
ex_store_data  output  XLEN  forwarded rs2 value, used for stores
fwd_a  output  2  A source: 00 stage register, 01 MEM/WB, 10 EX/MEM
fwd_b  output  2  rs2 source, same encoding as fwd_a

Behaviour:
- Reset (async, rst=1): all stage registers cleared.
  - ex_valid=0, ex_reg_write=0, ex_rd_addr=0, ALU_control=0000.
  - Held rs1/rs2 addresses, data and imm = 0; alu_src=0.
  - Result: A=0, B=0, ex_store_data=0, fwd_a=fwd_b=00.
- Priority at each posedge: flush > stall > load.
- Flush: valid=0, reg_write=0, rd_addr=0, ALU_control=0000, rs addresses=0, data and imm=0. A bubble yields A=B=0 and an ADD result of 0.
- Stall (flush=0): all fields held. Writeback capture: if wb_reg_write=1, wb_rd_addr≠0 and wb_rd_addr equals a held rs address, that held data register loads wb_result. rs1 and rs2 are checked independently.
- Load (stall=0, flush=0): all id_* fields are latched; ex_valid=id_valid.
  - id_valid=0 loads a bubble, with reg_write forced to 0.
  - Same-cycle WB bypass: if wb_reg_write=1, wb_rd_addr≠0 and wb_rd_addr==id_rsN_addr, wb_result is latched instead of id_rsN_data.
- Forwarding (combinational, from the held rs addresses):
  - EX/MEM hit: mem_reg_write=1, mem_rd_addr≠0 and mem_rd_addr==rsN → select 10.
  - Otherwise MEM/WB hit: same conditions on wb_* → select 01.
  - Otherwise → select 00.
  - EX/MEM wins when both hit. Address 0 is never forwarded.
- Operand outputs:
  - A = forwarded rs1.
  - B = id_alu_src-latched ? held imm : forwarded rs2.
  - ex_store_data = forwarded rs2 regardless of alu_src.
  - fwd_b reports the rs2 selection even when B takes the immediate.
- Latency: an instruction presented in cycle n drives A/B/ALU_control in cycle n+1; forwarded values pass through with zero latency.
- Widths: no arithmetic in this block; all paths are full XLEN with no truncation.
- rst asserted mid-stall or mid-flush overrides both immediately.

Test Plan:
- Reset: rst=1 with random inputs → A=0, B=0, ALU_control=0000, ex_valid=0, ex_reg_write=0, fwd_a=fwd_b=00.
- Plain load: rs1=3/data=10, rs2=4/data=20, alu_src=0, ctrl=0001, no forwarding → next cycle A=10, B=20, ALU_control=0001, fwd=00. Repeat with alu_src=1, imm=0xFFFFFFFC → B=0xFFFFFFFC, ex_store_data=20.
- Forward priority: held rs1=5; mem_rd=5/mem_result=0x55 and wb_rd=5/wb_result=0x66, both write → A=0x55, fwd_a=10. Drop mem_reg_write → A=0x66, fwd_a=01. Set mem_rd=0 with write → no forward from EX/MEM.
- x0 guard: held rs1=0, mem_rd=0, mem_reg_write=1, mem_result=0xDEAD → A=held value (0), fwd_a=00.
- Stall capture: hold stall=1 with rs2=7 held (data 1); wb writes x7=0x99 for one cycle, then wb idle; release stall → B=0x99 throughout. Also a same-cycle load with wb_rd=rs1 → latched wb_result.
- Flush vs stall: flush=1 and stall=1 together with valid id → next cycle ex_valid=0, ex_reg_write=0, A=B=0, ALU_control=0000.
